alt_ddr2_agx2_ex_rdata_checker: RTL and testbench
=================================================

// Module: alt_ddr2_agx2_ex_rdata_checker
// PURPOSE
//   Read-data checker for the DDR2 example driver. It consumes the expected
//   pattern from the per-byte 8-bit expected-data LFSR generators and compares
//   it byte-wise against local-interface read data. It drives the generators'
//   enable and pause inputs, and reports per-byte pass/not-fail, error count,
//   first failing beat, completion and timeout to the driver's top-level status.
// PARAMETERS
//   NUM_BYTES    8     bytes per local read beat; one generator per byte
//   BEAT_CNT_W   16    width of the beat counter and of num_beats
//   ERR_CNT_W    16    width of the saturating error counter
//   TIMEOUT_CYC  4096  CHECK-state cycles allowed between valid beats (>=2)
// PORTS
//   clk             in   1              clock
//   reset_n         in   1              reset, asynchronous, active-low
//   start           in   1              one-cycle pulse: begin a check of num_beats beats
//   num_beats       in   BEAT_CNT_W     beats to check; sampled on start
//   rdata           in   NUM_BYTES*8    read data; byte k is [8k+7:8k]
//   rdata_valid     in   1              rdata valid this cycle
//   exp_data        in   NUM_BYTES*8    expected data from the generators (byte k = generator k)
//   exp_enable      out  1              generator enable; low holds the generators at their seed
//   exp_pause       out  1              generator pause; low advances the generators one step
//   pnf_per_byte    out  NUM_BYTES      sticky pass-not-fail per byte (1 = no error seen)
//   pnf             out  1              AND of pnf_per_byte
//   err_count       out  ERR_CNT_W      beats with >=1 mismatching byte; saturates at all-ones
//   first_err_beat  out  BEAT_CNT_W     beat index of first mismatch; all-ones = none
//   busy            out  1              high in CHECK
//   done            out  1              high in DONE
//   timeout         out  1              sticky: check ended by timeout
// BEHAVIOUR
//   - Reset (async): state=IDLE; pnf_per_byte=all-ones; pnf=1; err_count=0;
//     first_err_beat=all-ones; busy=0; done=0; timeout=0; exp_enable=0; exp_pause=1.
//     Internal beat and timer counters clear. Reset mid-CHECK aborts; results are discarded.
//   - FSM IDLE -> CHECK -> DONE. start is accepted in IDLE or DONE and ignored in CHECK.
//   - start accepted: latch num_beats; clear pnf_per_byte to all-ones, err_count to 0,
//     first_err_beat to all-ones, timeout, beat_cnt and timer. Go to CHECK, or to DONE
//     next cycle if num_beats==0 (generators are never advanced).
//   - exp_enable = (state==CHECK), combinational. In IDLE/DONE the generators sit at
//     their seed, so the first CHECK beat compares against the seed value.
//   - exp_pause = ~(state==CHECK & rdata_valid), combinational. The generators advance on
//     the same edge that consumes a beat, so exp_data is always the pattern for the next beat.
//   - CHECK with rdata_valid (single-cycle compare, registered results):
//       mism[k] = rdata byte k != exp_data byte k; pnf_per_byte[k] &= ~mism[k].
//       If |mism: err_count += 1 (holds at all-ones). If first_err_beat is all-ones,
//       it takes beat_cnt.
//       beat_cnt += 1; timer = 0. If beat_cnt == num_beats-1, go to DONE next cycle.
//   - CHECK without rdata_valid: timer += 1. At timer == TIMEOUT_CYC-1: timeout=1, go to DONE.
//     A valid beat on that same cycle wins: it is compared and the timer clears.
//   - rdata_valid in IDLE/DONE is ignored: no compare, no counter change, generators held.
//   - pnf is registered alongside pnf_per_byte (same-cycle update).
//   - Outputs hold their values in DONE until the next accepted start or reset.
// TESTING
//   1 num_beats=16, correct LFSR pattern, random valid gaps -> done, pnf=1, pnf_per_byte=8'hFF,
//     err_count=0, timeout=0, generator stepped exactly 16 times.
//   2 Corrupt byte 3 on beat 5 of 16 -> pnf_per_byte=8'hF7, pnf=0, err_count=1, first_err_beat=5.
//   3 Corrupt bytes 0 and 7 on beat 2, byte 1 on beat 9 -> pnf_per_byte=8'h7C, err_count=2,
//     first_err_beat=2.
//   4 num_beats=10, deliver 6 beats then stop -> timeout=1 and done TIMEOUT_CYC cycles after
//     beat 6; err_count=0.
//   5 num_beats=0 -> done one cycle after start, exp_pause never low; then start num_beats=4
//     from DONE with a correct pattern -> pass.
//   6 reset_n low after beat 4 of 16 with an error on beat 1 -> all outputs at reset values
//     immediately; rerun of 16 correct beats passes. ERR_CNT_W=2 with 5 bad beats -> err_count=3.

Source files
------------

// File: rtl/alt_ddr2_agx2_ex_rdata_checker.sv
// Read-data checker: compares local read beats byte-wise against the
// expected-data LFSR generators and reports pass/fail, counts and timeout.
// Ports: clk, reset_n (async, active-low), start/num_beats (begin a check),
//   rdata/rdata_valid (read beats), exp_data (generator pattern),
//   exp_enable/exp_pause (generator control), pnf_per_byte, pnf, err_count,
//   first_err_beat, busy, done, timeout (status).
module alt_ddr2_agx2_ex_rdata_checker #(
    parameter int NUM_BYTES   = 8,
    parameter int BEAT_CNT_W  = 16,
    parameter int ERR_CNT_W   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [BEAT_CNT_W-1:0]   num_beats,
    input  logic [NUM_BYTES*8-1:0]  rdata,
    input  logic                    rdata_valid,
    input  logic [NUM_BYTES*8-1:0]  exp_data,
    output logic                    exp_enable,
    output logic                    exp_pause,
    output logic [NUM_BYTES-1:0]    pnf_per_byte,
    output logic                    pnf,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic [BEAT_CNT_W-1:0]   first_err_beat,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE   = 1;
    localparam logic [ERR_CNT_W-1:0]  ERR_ONE    = 1;
    localparam logic [TW-1:0]         TIMER_ONE  = 1;
    localparam logic [TW-1:0]         TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_CNT_W-1:0]   num_beats_q, num_beats_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [NUM_BYTES-1:0]    pnf_per_byte_q, pnf_per_byte_d;
    logic                    pnf_q, pnf_d;
    logic [ERR_CNT_W-1:0]    err_count_q, err_count_d;
    logic [BEAT_CNT_W-1:0]   first_err_beat_q, first_err_beat_d;
    logic                    timeout_q, timeout_d;

    logic [NUM_BYTES-1:0]    mism;
    logic [NUM_BYTES-1:0]    pnf_next;

    always_comb begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            mism[k] = rdata[8*k +: 8] != exp_data[8*k +: 8];
        end
        pnf_next = pnf_per_byte_q & ~mism;
    end

    always_comb begin
        state_d          = state_q;
        num_beats_d      = num_beats_q;
        beat_cnt_d       = beat_cnt_q;
        timer_d          = timer_q;
        pnf_per_byte_d   = pnf_per_byte_q;
        pnf_d            = pnf_q;
        err_count_d      = err_count_q;
        first_err_beat_d = first_err_beat_q;
        timeout_d        = timeout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_beats_d      = num_beats;
                    beat_cnt_d       = '0;
                    timer_d          = '0;
                    pnf_per_byte_d   = '1;
                    pnf_d            = 1'b1;
                    err_count_d      = '0;
                    first_err_beat_d = '1;
                    timeout_d        = 1'b0;
                    state_d = (num_beats == '0) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (rdata_valid) begin
                    pnf_per_byte_d = pnf_next;
                    pnf_d          = &pnf_next;
                    if (|mism) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_ONE;
                        end
                        if (first_err_beat_q == '1) begin
                            first_err_beat_d = beat_cnt_q;
                        end
                    end
                    beat_cnt_d = beat_cnt_q + BEAT_ONE;
                    timer_d    = '0;
                    if (beat_cnt_q == num_beats_q - BEAT_ONE) begin
                        state_d = S_DONE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            num_beats_q      <= '0;
            beat_cnt_q       <= '0;
            timer_q          <= '0;
            pnf_per_byte_q   <= '1;
            pnf_q            <= 1'b1;
            err_count_q      <= '0;
            first_err_beat_q <= '1;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            num_beats_q      <= num_beats_d;
            beat_cnt_q       <= beat_cnt_d;
            timer_q          <= timer_d;
            pnf_per_byte_q   <= pnf_per_byte_d;
            pnf_q            <= pnf_d;
            err_count_q      <= err_count_d;
            first_err_beat_q <= first_err_beat_d;
            timeout_q        <= timeout_d;
        end
    end

    // Generators step on the edge that consumes a beat, so exp_data
    // always presents the pattern for the next beat.
    assign exp_enable     = (state_q == S_CHECK);
    assign exp_pause      = ~((state_q == S_CHECK) & rdata_valid);
    assign pnf_per_byte   = pnf_per_byte_q;
    assign pnf            = pnf_q;
    assign err_count      = err_count_q;
    assign first_err_beat = first_err_beat_q;
    assign busy           = (state_q == S_CHECK);
    assign done           = (state_q == S_DONE);
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_alt_ddr2_agx2_ex_rdata_checker.sv
// Bench for the read-data checker: LFSR generator model, beat-level
// reference model and a per-cycle compare process; two DUT widths.
module tb_alt_ddr2_agx2_ex_rdata_checker;

    localparam int TC = 32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start = 1'b0;
    logic [15:0] num_beats = '0;
    logic [63:0] rdata = '0;
    logic        rdata_valid = 1'b0;
    logic [63:0] exp_data;

    logic        en0, pa0, pnf0, busy0, done0, to0;
    logic [7:0]  pnfb0;
    logic [15:0] err0, first0;
    logic        en1, pa1, pnf1, busy1, done1, to1;
    logic [7:0]  pnfb1;
    logic [1:0]  err1;
    logic [15:0] first1;

    always #5 clk = ~clk;

    alt_ddr2_agx2_ex_rdata_checker #(
        .NUM_BYTES(8), .BEAT_CNT_W(16), .ERR_CNT_W(16), .TIMEOUT_CYC(TC)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .start(start), .num_beats(num_beats),
        .rdata(rdata), .rdata_valid(rdata_valid), .exp_data(exp_data),
        .exp_enable(en0), .exp_pause(pa0), .pnf_per_byte(pnfb0), .pnf(pnf0),
        .err_count(err0), .first_err_beat(first0), .busy(busy0),
        .done(done0), .timeout(to0)
    );

    alt_ddr2_agx2_ex_rdata_checker #(
        .NUM_BYTES(8), .BEAT_CNT_W(16), .ERR_CNT_W(2), .TIMEOUT_CYC(TC)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .start(start), .num_beats(num_beats),
        .rdata(rdata), .rdata_valid(rdata_valid), .exp_data(exp_data),
        .exp_enable(en1), .exp_pause(pa1), .pnf_per_byte(pnfb1), .pnf(pnf1),
        .err_count(err1), .first_err_beat(first1), .busy(busy1),
        .done(done1), .timeout(to1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [7:0] seed(input int k);
        return 8'(1 + 29 * k);
    endfunction

    // Expected pattern of beat i: each byte's seed stepped i times.
    function automatic logic [63:0] pattern(input int i);
        logic [63:0] p;
        logic [7:0]  x;
        for (int k = 0; k < 8; k++) begin
            x = seed(k);
            for (int j = 0; j < i; j++) x = lfsr_step(x);
            p[8*k +: 8] = x;
        end
        return p;
    endfunction

    function automatic logic [63:0] corrupt(input logic [7:0] m);
        logic [63:0] c;
        c = '0;
        for (int k = 0; k < 8; k++)
            if (m[k]) c[8*k +: 8] = 8'($urandom_range(1, 255));
        return c;
    endfunction

    // Generator model driven by DUT 0's enable/pause.
    logic [7:0] gen [8];
    int steps = 0;
    int cyc = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) gen[k] <= seed(k);
        end else begin
            cyc <= cyc + 1;
            if (en0 && !pa0) steps <= steps + 1;
            for (int k = 0; k < 8; k++) begin
                if (!en0) gen[k] <= seed(k);
                else if (!pa0) gen[k] <= lfsr_step(gen[k]);
            end
        end
    end

    always_comb begin
        exp_data = '0;
        for (int k = 0; k < 8; k++) exp_data[8*k +: 8] = gen[k];
    end

    // Reference model: 0 idle, 1 check, 2 done; results derive from
    // the set of beats consumed and the per-beat corruption masks.
    logic [7:0] bm   [64];
    logic [7:0] m_bm [64];
    int m_state = 0;
    int m_n = 0;
    int m_cons = 0;
    int m_gap = 0;
    bit m_tout = 1'b0;
    bit cmp_en = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state <= 0;
            m_cons  <= 0;
            m_gap   <= 0;
            m_tout  <= 1'b0;
        end else if (m_state != 1) begin
            if (start) begin
                m_n     <= int'(num_beats);
                m_cons  <= 0;
                m_gap   <= 0;
                m_tout  <= 1'b0;
                m_state <= (num_beats == 0) ? 2 : 1;
                for (int i = 0; i < 64; i++) m_bm[i] <= bm[i];
            end
        end else if (rdata_valid) begin
            m_cons <= m_cons + 1;
            m_gap  <= 0;
            if (m_cons + 1 == m_n) m_state <= 2;
        end else begin
            m_gap <= m_gap + 1;
            if (m_gap + 1 == TC) begin
                m_tout  <= 1'b1;
                m_state <= 2;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0]  e_pnfb;
        logic [15:0] e_first;
        int          e_err;
        if (cmp_en) begin
            e_pnfb  = 8'hFF;
            e_first = 16'hFFFF;
            e_err   = 0;
            for (int i = 0; i < m_cons; i++) begin
                e_pnfb &= ~m_bm[i];
                if (m_bm[i] != 0) begin
                    e_err++;
                    if (e_first == 16'hFFFF) e_first = 16'(i);
                end
            end
            chk("busy", busy0, m_state == 1);
            chk("done", done0, m_state == 2);
            chk("timeout", to0, m_tout);
            chk("exp_enable", en0, m_state == 1);
            chk("exp_pause", pa0, !(m_state == 1 && rdata_valid));
            chk("pnf_per_byte", pnfb0, e_pnfb);
            chk("pnf", pnf0, &e_pnfb);
            chk("err_count", err0, 64'(e_err));
            chk("first_err_beat", first0, e_first);
            chk("err_count_w2", err1, (e_err > 3) ? 3 : e_err);
            chk("pnf_per_byte_w2", pnfb1, e_pnfb);
            chk("done_w2", done1, m_state == 2);
            chk("exp_pause_w2", pa1, !(m_state == 1 && rdata_valid));
        end
    end

    int t_stop = 0;
    int t_done = 0;

    task automatic clear_bm();
        for (int i = 0; i < 64; i++) bm[i] = 8'h00;
    endtask

    task automatic run(input int n, input int gap, input int stop_after,
                       input int abort_after);
        int d = 0;
        int c = 0;
        bit ab = 1'b0;
        start = 1'b1;
        num_beats = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (m_state == 1 && c < 40 * n + 4 * TC + 100 && !ab) begin
            if (d < stop_after && $urandom_range(99) >= gap) begin
                rdata_valid = 1'b1;
                rdata = pattern(d) ^ corrupt(bm[d]);
            end else begin
                rdata_valid = 1'b0;
                rdata = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            c++;
            if (rdata_valid) begin
                d++;
                if (d == stop_after) t_stop = cyc;
                if (d == abort_after) begin
                    rdata_valid = 1'b0;
                    chk("pre_reset_err", err0, 1);
                    reset_n = 1'b0;
                    #1;
                    chk("rst_pnfb", pnfb0, 8'hFF);
                    chk("rst_pnf", pnf0, 1);
                    chk("rst_err", err0, 0);
                    chk("rst_first", first0, 16'hFFFF);
                    chk("rst_busy", busy0, 0);
                    chk("rst_enable", en0, 0);
                    chk("rst_pause", pa0, 1);
                    @(posedge clk); #1;
                    reset_n = 1'b1;
                    ab = 1'b1;
                end
            end
        end
        rdata_valid = 1'b0;
        t_done = cyc;
        if (!ab) chk("run_done", done0, 1);
    endtask

    initial begin
        logic [63:0] pv;
        int s0;
        reset_n = 1'b1;
        clear_bm();
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_pnfb", pnfb0, 8'hFF);
        chk("reset_first", first0, 16'hFFFF);
        chk("reset_pause", pa0, 1);
        pv = pattern(4);
        chk("lfsr_model", pv[7:0], 8'h11);
        @(posedge clk); #1;

        s0 = steps;
        run(16, 30, 99, -1);
        chk("t1_pnfb", pnfb0, 8'hFF);
        chk("t1_err", err0, 0);
        chk("t1_timeout", to0, 0);
        chk("t1_steps", 64'(steps - s0), 16);

        clear_bm();
        bm[5] = 8'h08;
        run(16, 30, 99, -1);
        chk("t2_pnfb", pnfb0, 8'hF7);
        chk("t2_pnf", pnf0, 0);
        chk("t2_err", err0, 1);
        chk("t2_first", first0, 5);

        clear_bm();
        bm[2] = 8'h81;
        bm[9] = 8'h02;
        run(16, 30, 99, -1);
        chk("t3_pnfb", pnfb0, 8'h7C);
        chk("t3_err", err0, 2);
        chk("t3_first", first0, 2);

        for (int i = 0; i < 3; i++) begin
            rdata_valid = 1'b1;
            rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        rdata_valid = 1'b0;
        chk("ignore_done_err", err0, 2);

        clear_bm();
        run(10, 20, 6, -1);
        chk("t4_timeout", to0, 1);
        chk("t4_err", err0, 0);
        chk("t4_latency", 64'(t_done - t_stop), TC);

        s0 = steps;
        run(0, 0, 99, -1);
        chk("t5_done", done0, 1);
        @(posedge clk); #1;
        chk("t5_steps", 64'(steps - s0), 0);
        run(4, 30, 99, -1);
        chk("t5_pass", pnf0, 1);
        chk("t5_timeout", to0, 0);

        bm[1] = 8'h10;
        run(16, 30, 99, 4);
        clear_bm();
        run(16, 30, 99, -1);
        chk("t6_pass", pnf0, 1);
        chk("t6_err", err0, 0);

        for (int i = 0; i < 5; i++) bm[i] = 8'h01 << i;
        run(8, 10, 99, -1);
        chk("sat_err16", err0, 5);
        chk("sat_err2", err1, 3);

        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 40);
            clear_bm();
            for (int i = 0; i < n; i++)
                if ($urandom_range(9) == 0) bm[i] = 8'($urandom_range(1, 255));
            run(n, $urandom_range(0, 60), (r == 2) ? n / 2 : 99, -1);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
